// File: rtl/ahb_master_seq_pkg.sv
// Shared types and constants for the AHB master traffic sequencer.
// FSM state encoding, transfer phase and sequence mode encodings.
package ahb_master_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_XFER = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    typedef enum logic {
        PH_WRITE = 1'b0,
        PH_READ  = 1'b1
    } phase_t;

    localparam logic [1:0] MODE_WR    = 2'b00;
    localparam logic [1:0] MODE_RD    = 2'b01;
    localparam logic [1:0] MODE_WRCHK = 2'b10;
    localparam logic [1:0] MODE_LOOP  = 2'b11;

    // Modes whose read phase compares returned data against the write pattern.
    function automatic logic mode_checks(input logic [1:0] m);
        return (m == MODE_WRCHK) || (m == MODE_LOOP);
    endfunction

endpackage

// File: rtl/ahb_master_seq_timeout.sv
// Per-transfer watchdog: counts cycles while enabled, clears to zero on clr,
// and flags the cycle in which the TIMEOUT-th enabled cycle is reached.
module ahb_master_seq_timeout #(
    parameter int TIMEOUT = 64
) (
    input  logic hclk,
    input  logic hreset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ahb_master_seq.sv
// AHB master traffic sequencer: issues programmed write/read streams to the
// master interface, optionally checks read-back data, and guards each transfer.
module ahb_master_seq
    import ahb_master_seq_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int SEL_W     = 2,
    parameter int NUM_XFERS = 8,
    parameter int ADDR_STEP = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DATA_W-1:0] seed,
    input  logic [SEL_W-1:0]  slv_sel_cfg,
    input  logic              hgrant,
    input  logic              xfer_done,
    input  logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] addr,
    output logic [SEL_W-1:0]  slv_sel_in,
    output logic [DATA_W-1:0] din,
    output logic              wr,
    output logic              enable,
    output logic              hbusreq_in,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_cnt,
    output logic              timeout_err
);

    localparam int               IDX_W    = (NUM_XFERS > 1) ? $clog2(NUM_XFERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_XFERS - 1);

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] seed_q;
    logic [SEL_W-1:0]  sel_q;
    logic              to_expired;

    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] din_d;
    logic [SEL_W-1:0]  sel_d;
    logic              wr_d, enable_d, hbusreq_d, busy_d, done_d, terr_d;
    logic [15:0]       err_d;
    logic              launch, rd_mismatch;

    assign launch      = (state_q == S_IDLE) && start;
    assign rd_mismatch = (dout != seed_q + DATA_W'(idx_q));

    ahb_master_seq_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .hclk    (hclk),
        .hreset  (hreset),
        .clr     (state_q != S_XFER),
        .en      (state_q == S_XFER),
        .expired (to_expired)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_WRITE;
            idx_q       <= '0;
            mode_q      <= MODE_WR;
            base_q      <= '0;
            seed_q      <= '0;
            sel_q       <= '0;
            addr        <= '0;
            din         <= '0;
            slv_sel_in  <= '0;
            wr          <= 1'b0;
            enable      <= 1'b0;
            hbusreq_in  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            if (launch) begin
                mode_q <= mode;
                base_q <= base_addr;
                seed_q <= seed;
                sel_q  <= slv_sel_cfg;
            end
            addr        <= addr_d;
            din         <= din_d;
            slv_sel_in  <= sel_d;
            wr          <= wr_d;
            enable      <= enable_d;
            hbusreq_in  <= hbusreq_d;
            busy        <= busy_d;
            done        <= done_d;
            err_cnt     <= err_d;
            timeout_err <= terr_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    idx_d   = '0;
                    phase_d = (mode == MODE_RD) ? PH_READ : PH_WRITE;
                end
            end
            S_REQ: begin
                if (hgrant) state_d = S_XFER;
            end
            S_XFER: begin
                if (xfer_done)       state_d = S_GAP;
                else if (to_expired) state_d = S_DONE;
            end
            S_GAP: begin
                if (idx_q != LAST_IDX) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = hgrant ? S_XFER : S_REQ;
                end else if (phase_q == PH_WRITE && mode_checks(mode_q)) begin
                    phase_d = PH_READ;
                    idx_d   = '0;
                    state_d = hgrant ? S_XFER : S_REQ;
                end else if (phase_q == PH_READ && mode_q == MODE_LOOP) begin
                    phase_d = PH_WRITE;
                    idx_d   = '0;
                    state_d = !start ? S_DONE : (hgrant ? S_XFER : S_REQ);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the next state.
    always_comb begin
        addr_d    = addr;
        din_d     = din;
        sel_d     = slv_sel_in;
        wr_d      = wr;
        err_d     = err_cnt;
        terr_d    = timeout_err;
        enable_d  = (state_d == S_XFER);
        hbusreq_d = state_d inside {S_REQ, S_XFER, S_GAP};
        busy_d    = state_d inside {S_REQ, S_XFER, S_GAP};
        done_d    = (state_d == S_DONE);

        // Command fields are loaded once on XFER entry and held until completion.
        if (state_d == S_XFER && state_q != S_XFER) begin
            addr_d = base_q + ADDR_W'(idx_d) * ADDR_W'(ADDR_STEP);
            din_d  = seed_q + DATA_W'(idx_d);
            wr_d   = (phase_d == PH_WRITE);
            sel_d  = sel_q;
        end

        if (launch) begin
            err_d  = '0;
            terr_d = 1'b0;
        end

        if (state_q == S_XFER && xfer_done && phase_q == PH_READ &&
            mode_checks(mode_q) && rd_mismatch && err_cnt != 16'hFFFF) begin
            err_d = err_cnt + 16'd1;
        end

        if (state_q == S_XFER && !xfer_done && to_expired) begin
            terr_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_ahb_master_seq.sv
// Self-checking bench for ahb_master_seq: table of sequence scenarios driven
// through a small slave model, plus hand-written timeout and reset sequences.
module tb_ahb_master_seq;

    localparam int NX = 4;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] base_addr;
    logic [31:0] seed;
    logic [1:0]  slv_sel_cfg;
    logic        hgrant;
    logic        xfer_done;
    logic [31:0] dout;
    logic [31:0] addr;
    logic [1:0]  slv_sel_in;
    logic [31:0] din;
    logic        wr, enable, hbusreq_in, busy, done, timeout_err;
    logic [15:0] err_cnt;

    int tests = 0;
    int fails = 0;

    always #5 hclk = ~hclk;

    ahb_master_seq #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .SEL_W     (2),
        .NUM_XFERS (NX),
        .ADDR_STEP (4),
        .TIMEOUT   (8)
    ) dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .start       (start),
        .mode        (mode),
        .base_addr   (base_addr),
        .seed        (seed),
        .slv_sel_cfg (slv_sel_cfg),
        .hgrant      (hgrant),
        .xfer_done   (xfer_done),
        .dout        (dout),
        .addr        (addr),
        .slv_sel_in  (slv_sel_in),
        .din         (din),
        .wr          (wr),
        .enable      (enable),
        .hbusreq_in  (hbusreq_in),
        .busy        (busy),
        .done        (done),
        .err_cnt     (err_cnt),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] base;
        logic [31:0] seed;
        int          delay;      // enable cycles before xfer_done
        int          bad_idx;    // read index answered with 0xDEADBEEF, -1 none
        int          drop_at;    // drop grant in the GAP after this index, -1 none
        int          exp_xfers;
        int          exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"}, 64'(addr), 64'h0);
        check({tag, "_din"}, 64'(din), 64'h0);
        check({tag, "_ctl"}, 64'({slv_sel_in, wr, enable, hbusreq_in, busy, done, timeout_err}), 64'h0);
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'h0);
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int          n, cyc, wait_cnt, done_seen, first_en, hold, ix;
        logic        prev_en, exp_wr;
        logic [31:0] exp_addr, exp_din;
        n = 0; cyc = 0; wait_cnt = 0; done_seen = 0; first_en = -1; hold = 0;
        prev_en = 1'b0;
        @(negedge hclk);
        mode = v.mode; base_addr = v.base; seed = v.seed; slv_sel_cfg = 2'd2;
        hgrant = 1'b1; xfer_done = 1'b0; start = 1'b1;
        while (done_seen == 0 && cyc < 600) begin
            @(negedge hclk);
            cyc++;
            start = 1'b0;
            xfer_done = 1'b0;
            if (done) done_seen = 1;
            if (v.drop_at >= 0 && prev_en && !enable && n == v.drop_at + 1 && hold == 0 && hgrant) begin
                hgrant = 1'b0;
                hold = 5;
            end else if (hold > 0) begin
                check($sformatf("v%0d_gap_hold", vi), 64'({enable, hbusreq_in}), 64'h1);
                hold--;
                if (hold == 0) hgrant = 1'b1;
            end
            if (enable && !prev_en) begin
                ix       = n % NX;
                exp_wr   = (v.mode == 2'b00) || (v.mode[1] && n < NX);
                exp_addr = v.base + 32'(ix * 4);
                exp_din  = v.seed + 32'(ix);
                check($sformatf("v%0d_x%0d_addr", vi, n), 64'(addr), 64'(exp_addr));
                check($sformatf("v%0d_x%0d_din", vi, n), 64'(din), 64'(exp_din));
                check($sformatf("v%0d_x%0d_wr", vi, n), 64'(wr), 64'(exp_wr));
                check($sformatf("v%0d_x%0d_sel", vi, n), 64'(slv_sel_in), 64'h2);
                if (first_en < 0) first_en = cyc;
                n++;
                wait_cnt = 0;
            end
            if (enable) begin
                wait_cnt++;
                if (wait_cnt == v.delay) begin
                    ix = (n - 1) % NX;
                    exp_wr = (v.mode == 2'b00) || (v.mode[1] && (n - 1) < NX);
                    dout = (!exp_wr && ix == v.bad_idx) ? 32'hDEADBEEF : v.seed + 32'(ix);
                    xfer_done = 1'b1;
                end
            end
            prev_en = enable;
        end
        check($sformatf("v%0d_done_seen", vi), 64'(done_seen), 64'h1);
        check($sformatf("v%0d_first_en_latency", vi), 64'(first_en), 64'h2);
        check($sformatf("v%0d_xfer_count", vi), 64'(n), 64'(v.exp_xfers));
        check($sformatf("v%0d_busy_at_done", vi), 64'({busy, hbusreq_in, enable}), 64'h0);
        check($sformatf("v%0d_err_cnt", vi), 64'(err_cnt), 64'(v.exp_err));
        check($sformatf("v%0d_timeout_err", vi), 64'(timeout_err), 64'h0);
        @(negedge hclk);
        check($sformatf("v%0d_done_one_cycle", vi), 64'(done), 64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, en_cnt;
        vecs[0] = '{2'b00, 32'h100,      32'hA5A50000, 3, -1, -1, 4, 0};
        vecs[1] = '{2'b10, 32'h100,      32'hA5A50000, 3,  2, -1, 8, 1};
        vecs[2] = '{2'b00, 32'h100,      32'hA5A50000, 3, -1,  1, 4, 0};
        vecs[3] = '{2'b01, 32'hFFFFFFF8, 32'hA5A50000, 3,  1, -1, 4, 0};
        vecs[4] = '{2'b11, 32'h100,      32'hA5A50000, 2,  0, -1, 8, 1};
        vecs[5] = '{2'b00, 32'h200,      32'h00000000, 8, -1, -1, 4, 0};
        vecs[6] = '{2'b10, 32'h100,      32'hA5A50000, 1, -1, -1, 8, 0};

        hreset = 1'b1; start = 1'b0; mode = 2'b00; base_addr = '0; seed = '0;
        slv_sel_cfg = '0; hgrant = 1'b0; xfer_done = 1'b0; dout = '0;
        repeat (3) @(negedge hclk);
        check_zero("reset");
        hreset = 1'b0;
        @(negedge hclk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Transfer that never completes: enable must stay high exactly TIMEOUT cycles.
        @(negedge hclk);
        mode = 2'b00; base_addr = 32'h300; seed = 32'h1; slv_sel_cfg = 2'd1;
        hgrant = 1'b1; xfer_done = 1'b0; start = 1'b1;
        cyc = 0; en_cnt = 0;
        while (!done && cyc < 100) begin
            @(negedge hclk);
            start = 1'b0;
            cyc++;
            if (enable) en_cnt++;
        end
        check("to_enable_cycles", 64'(en_cnt), 64'd8);
        check("to_done", 64'(done), 64'h1);
        check("to_timeout_err", 64'(timeout_err), 64'h1);
        check("to_bus_released", 64'({busy, hbusreq_in, enable}), 64'h0);
        @(negedge hclk);
        check("to_done_one_cycle", 64'(done), 64'h0);
        check("to_err_sticky", 64'(timeout_err), 64'h1);

        // Restart clears the sticky flag; reset lands one cycle after enable rises.
        @(negedge hclk);
        mode = 2'b00; base_addr = 32'h100; seed = 32'hA5A50000; slv_sel_cfg = 2'd2;
        start = 1'b1;
        @(negedge hclk);
        start = 1'b0;
        check("rst_seq_cleared_to_err", 64'({timeout_err, busy}), 64'h1);
        @(negedge hclk);
        check("rst_seq_enable_up", 64'(enable), 64'h1);
        @(negedge hclk);
        hreset = 1'b1;
        #1;
        check_zero("midreset");
        @(negedge hclk);
        check("midreset_no_done", 64'(done), 64'h0);
        hreset = 1'b0;
        run_vec(vecs[0], 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
